seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Decodes a multiplexed 4-digit 7-segment bus (active-low anode select plus segment byte) back into per-digit hex values.
//  It is the read side of our display drivers: it sits on the same control/display nets and reports what is actually shown.
//  The block filters scan transients, flags illegal glyphs and anode conflicts, and pulses once per complete 4-digit frame.
// PARAMETERS
//  STABLE_CYCLES   4        consecutive identical bus samples required before a capture (>=1)
//  TIMEOUT_CYCLES  4000000  cycles without a capture after which a digit is marked stale
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  reset       in   1   synchronous, active-high
//  control     in   4   anode select, active low; control[3]=leftmost digit (pos 3), control[0]=pos 0
//  display     in   8   segments active high: [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp
//  digits      out  16  decoded hex per position, digits[4p+3:4p]=pos p
//  dp          out  4   captured decimal point per position
//  valid       out  4   position holds a fresh, legal glyph
//  blank       out  4   last capture for the position had all segments a..g off
//  glyph_err   out  4   last capture for the position was not in the glyph table
//  bus_err     out  1   1-cycle pulse: a stable sample had more than one anode low
//  frame_done  out  1   1-cycle pulse: all four positions captured since the previous pulse
// BEHAVIOUR
//  - Reset values: digits=0, dp=0, valid=0, blank=0, glyph_err=0, bus_err=0, frame_done=0. All internal counters and masks are cleared.
//  - Reset asserted mid-operation clears everything at that edge. The input register is also cleared to control=4'hF.
//  - control and display are registered once into in_q. stab_cnt counts consecutive cycles in which in_q is unchanged.
//    It saturates and restarts at 0 on any change.
//  - Capture fires once per dwell, on the edge where stab_cnt reaches STABLE_CYCLES-1. Outputs are then visible STABLE_CYCLES+1 edges after the bus settles.
//    No re-capture happens until in_q changes.
//  - Capture with exactly one anode low at pos p:
//    - dp[p] <= display[0].
//    - If display[7:1] matches the glyph table: digits[p] <= code, valid[p] <= 1, glyph_err[p] <= 0, blank[p] <= 0.
//    - If display[7:1] == 0: blank[p] <= 1, valid[p] <= 0, glyph_err[p] <= 0, and digits[p] holds.
//    - Otherwise: glyph_err[p] <= 1, valid[p] <= 0, and digits[p] holds.
//    - In all three cases seen[p] <= 1 and tmo_cnt[p] <= 0.
//  - Stable control==4'hF: idle, no capture, no error.
//  - Stable sample with two or more anodes low: bus_err pulses once for that dwell. Nothing is captured.
//  - Glyph table, segment bits a..g:
//    0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000
//    8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111
//  - Frame: a 4-bit seen mask. When the mask would become 4'hF, frame_done pulses on that same edge and the mask is cleared.
//    A capture on that edge counts toward the completed frame.
//  - Timeout: each position has tmo_cnt[p], counting up and saturating. At TIMEOUT_CYCLES-1 with no capture, valid[p] <= 0.
//    digits, dp and blank hold. If a capture and a timeout land on the same edge, the capture wins.
//  - Counter widths are $clog2 of the terminal value plus 1, with no wrap-around, so saturation is guaranteed.
// STRUCTURE
//  - seg7_pkg holds the 16 glyph localparams, the position/anode constants (4'b0111 .. 4'b1110) and DIGITS=4.
//  - seg7_glyph_decode is a combinational sub-module: 7-bit segments in, {hit, blank, code[3:0]} out. It is shared with future display checkers.
//  - The top level holds the input register, stability counter, capture FSM (IDLE/SETTLE/HELD), seen mask and timeout counters.
// TESTING
//  - Hold control=4'b0111, display=8'b11111101 for 10 cycles -> after 5 edges: digits[15:12]=0, dp[3]=1, valid=4'b1000, no repeat capture.
//  - Drive 4'b0111/0x60, 4'b1011/0xDA, 4'b1101/0xF2, 4'b1110/0x66, each for 6 cycles -> digits=16'h1234, valid=4'hF.
//    frame_done pulses exactly once, on the 4th capture.
//  - Glitch: change display every 2 cycles with STABLE_CYCLES=4 -> no capture, outputs unchanged.
//    Then 1 stable dwell -> single capture.
//  - control=4'b0011 stable for 6 cycles -> bus_err one pulse, digits/valid unchanged.
//    Then display=0xAA on pos 0 -> glyph_err[0]=1, valid[0]=0.
//  - Use TIMEOUT_CYCLES=50. Capture pos 1, then idle control=4'hF -> valid[1] drops exactly 50 cycles after the capture, digits[7:4] held.
//  - Assert reset during a SETTLE dwell -> next edge all outputs 0. Re-release -> fresh capture after STABLE_CYCLES+1 edges.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: glyph table, anode patterns, result types.
package seg7_pkg;

  localparam int DIGITS = 4;

  // Segment order a..g, a in the MSB
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  localparam logic [15:0][6:0] GLYPH_TBL = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  localparam logic [3:0] ANODE_POS3 = 4'b0111;
  localparam logic [3:0] ANODE_POS2 = 4'b1011;
  localparam logic [3:0] ANODE_POS1 = 4'b1101;
  localparam logic [3:0] ANODE_POS0 = 4'b1110;
  localparam logic [3:0] ANODE_NONE = 4'b1111;
  localparam logic [DIGITS-1:0][3:0] ANODE_SEL = {ANODE_POS3, ANODE_POS2, ANODE_POS1, ANODE_POS0};

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] code;
  } glyph_res_t;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} cap_state_e;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Display bus observed by the decoder plus the decoded status it reports.
interface seg7_scan_decoder_if;
  logic [3:0]  control;
  logic [7:0]  display;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  valid;
  logic [3:0]  blank;
  logic [3:0]  glyph_err;
  logic        bus_err;
  logic        frame_done;

  modport master (output control, display,
                  input  digits, dp, valid, blank, glyph_err, bus_err, frame_done);
  modport slave  (input  control, display,
                  output digits, dp, valid, blank, glyph_err, bus_err, frame_done);
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational a..g segment pattern to hex code lookup; also flags the all-off pattern.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output glyph_res_t o_res
);

  always_comb begin
    o_res       = '0;
    o_res.blank = (i_seg == 7'b0);
    for (int i = 0; i < 16; i++) begin
      if (i_seg == GLYPH_TBL[i]) begin
        o_res.hit  = 1'b1;
        o_res.code = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Read-back decoder for a multiplexed 4-digit 7-segment bus: filters scan transients,
// captures one glyph per stable dwell, tracks frames and per-digit staleness.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_decoder_if.slave  bus
);

  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]                  r_ctrl_q;
  logic [7:0]                  r_disp_q;
  logic [SW-1:0]               r_stab_cnt;
  cap_state_e                  r_state;
  logic [DIGITS-1:0]           r_seen;
  logic [DIGITS-1:0][TW-1:0]   r_tmo_cnt;
  logic [DIGITS-1:0][3:0]      r_digits;
  logic [DIGITS-1:0]           r_dp, r_valid, r_blank, r_glyph_err;
  logic                        r_bus_err, r_frame_done;

  logic                        w_changed, w_fire, w_one_hot, w_idle, w_cap, w_frame;
  logic [DIGITS-1:0]           w_hit_p, w_seen_nxt;
  glyph_res_t                  w_glyph;

  seg7_glyph_decode u_glyph (.i_seg(r_disp_q[7:1]), .o_res(w_glyph));

  assign w_changed  = {bus.control, bus.display} != {r_ctrl_q, r_disp_q};
  // The counter value reflects how long the sample currently in in_q has been stable
  assign w_fire     = (r_state == SETTLE) && (r_stab_cnt == STAB_MAX);
  assign w_one_hot  = ($countones(~r_ctrl_q) == 1);
  assign w_idle     = (r_ctrl_q == ANODE_NONE);
  assign w_cap      = w_fire && w_one_hot;
  assign w_seen_nxt = r_seen | w_hit_p;
  assign w_frame    = (w_seen_nxt == {DIGITS{1'b1}});

  always_comb begin
    w_hit_p = '0;
    for (int p = 0; p < DIGITS; p++)
      w_hit_p[p] = w_cap && (r_ctrl_q == ANODE_SEL[p]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_q     <= ANODE_NONE;
      r_disp_q     <= '0;
      r_stab_cnt   <= '0;
      r_state      <= IDLE;
      r_seen       <= '0;
      r_tmo_cnt    <= '0;
      r_digits     <= '0;
      r_dp         <= '0;
      r_valid      <= '0;
      r_blank      <= '0;
      r_glyph_err  <= '0;
      r_bus_err    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_ctrl_q <= bus.control;
      r_disp_q <= bus.display;
      if (w_changed) begin
        r_stab_cnt <= '0;
        r_state    <= SETTLE;
      end else begin
        if (r_stab_cnt != STAB_MAX) r_stab_cnt <= r_stab_cnt + 1'b1;
        if (w_fire) r_state <= HELD;
      end
      r_bus_err    <= w_fire && !w_one_hot && !w_idle;
      r_frame_done <= w_frame;
      r_seen       <= w_frame ? '0 : w_seen_nxt;
      for (int p = 0; p < DIGITS; p++) begin
        if (w_hit_p[p]) begin
          r_tmo_cnt[p] <= '0;
          r_dp[p]      <= r_disp_q[0];
          if (w_glyph.hit) begin
            r_digits[p]    <= w_glyph.code;
            r_valid[p]     <= 1'b1;
            r_glyph_err[p] <= 1'b0;
            r_blank[p]     <= 1'b0;
          end else if (w_glyph.blank) begin
            r_blank[p]     <= 1'b1;
            r_valid[p]     <= 1'b0;
            r_glyph_err[p] <= 1'b0;
          end else begin
            r_glyph_err[p] <= 1'b1;
            r_valid[p]     <= 1'b0;
            r_blank[p]     <= 1'b0;
          end
        end else if (r_tmo_cnt[p] != TMO_MAX) begin
          r_tmo_cnt[p] <= r_tmo_cnt[p] + 1'b1;
        end else begin
          r_valid[p] <= 1'b0;
        end
      end
    end
  end

  assign bus.digits     = r_digits;
  assign bus.dp         = r_dp;
  assign bus.valid      = r_valid;
  assign bus.blank      = r_blank;
  assign bus.glyph_err  = r_glyph_err;
  assign bus.bus_err    = r_bus_err;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed table-driven bench for seg7_scan_decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=50.
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n_frames = 0;
  int   n_buserr = 0;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_done) n_frames++;
      if (bus.bus_err)    n_buserr++;
    end
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic [7:0]  disp;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  gerr;
    int          frames;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [7:0] d);
    bus.control = c;
    bus.display = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'hF, 8'h00);
    step(2);
    reset = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] dg, input logic [3:0] v,
                         input logic [3:0] dp, input logic [3:0] b, input logic [3:0] g);
    chk({tag, ".digits"}, 32'(bus.digits), 32'(dg));
    chk({tag, ".valid"},  32'(bus.valid),  32'(v));
    chk({tag, ".dp"},     32'(bus.dp),     32'(dp));
    chk({tag, ".blank"},  32'(bus.blank),  32'(b));
    chk({tag, ".gerr"},   32'(bus.glyph_err), 32'(g));
  endtask

  initial begin
    vecs[0] = '{4'b0111, 8'h60, 16'h1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[1] = '{4'b1011, 8'hDA, 16'h1200, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[2] = '{4'b1101, 8'hF2, 16'h1230, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 0};
    vecs[3] = '{4'b1110, 8'h66, 16'h1234, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1};
    vecs[4] = '{4'b1110, 8'hAA, 16'h1234, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 1};
    vecs[5] = '{4'b1101, 8'h00, 16'h1234, 4'b1100, 4'b0000, 4'b0010, 4'b0001, 1};
    vecs[6] = '{4'b1110, 8'h67, 16'h1234, 4'b1101, 4'b0001, 4'b0010, 4'b0000, 1};
    vecs[7] = '{4'b0111, 8'h01, 16'h1234, 4'b0101, 4'b1001, 4'b1010, 4'b0000, 1};
    vecs[8] = '{4'b1011, 8'hEE, 16'h1A34, 4'b0101, 4'b1001, 4'b1010, 4'b0000, 2};

    // Reset state
    drive(4'hF, 8'h00);
    step(3);
    chk_all("reset", 16'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("reset.bus_err", 32'(bus.bus_err), 0);
    chk("reset.frame_done", 32'(bus.frame_done), 0);
    reset = 1'b0;

    // Single capture latency: STABLE_CYCLES+1 edges
    drive(4'b0111, 8'hFD);
    step(4);
    chk("lat.early_valid", 32'(bus.valid), 0);
    step(1);
    chk_all("lat", 16'h0000, 4'b1000, 4'b1000, 4'h0, 4'h0);
    step(5);
    chk_all("lat.hold", 16'h0000, 4'b1000, 4'b1000, 4'h0, 4'h0);

    // Frame and glyph table sequence
    do_reset();
    n_frames = 0;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ctrl, vecs[i].disp);
      step(6);
      chk_all($sformatf("vec%0d", i), vecs[i].digits, vecs[i].valid, vecs[i].dp,
              vecs[i].blank, vecs[i].gerr);
      chk($sformatf("vec%0d.frames", i), 32'(n_frames), 32'(vecs[i].frames));
    end

    // Glitching display never settles long enough to capture
    for (int i = 0; i < 6; i++) begin
      drive(4'b1110, i[0] ? 8'hDA : 8'h60);
      step(2);
    end
    chk_all("glitch", 16'h1A34, 4'b0101, 4'b1001, 4'b1010, 4'b0000);
    drive(4'b1110, 8'h60);
    step(6);
    chk_all("glitch.dwell", 16'h1A31, 4'b0101, 4'b1000, 4'b1010, 4'b0000);
    chk("glitch.frames", 32'(n_frames), 2);

    // Anode conflict, then illegal glyph on pos 0
    n_buserr = 0;
    drive(4'b0011, 8'h60);
    step(6);
    chk("conflict.count", 32'(n_buserr), 1);
    chk_all("conflict", 16'h1A31, 4'b0101, 4'b1000, 4'b1010, 4'b0000);
    drive(4'b1110, 8'hAA);
    step(6);
    chk_all("illegal", 16'h1A31, 4'b0100, 4'b1000, 4'b1010, 4'b0001);
    chk("illegal.buserr", 32'(n_buserr), 1);

    // Staleness timeout: valid drops exactly 50 edges after the capture edge
    do_reset();
    drive(4'b1101, 8'h66);
    step(5);
    chk("tmo.cap", 32'(bus.valid), 32'(4'b0010));
    drive(4'hF, 8'h00);
    step(49);
    chk("tmo.before", 32'(bus.valid), 32'(4'b0010));
    step(1);
    chk("tmo.after", 32'(bus.valid), 0);
    chk("tmo.digits", 32'(bus.digits), 32'(16'h0040));

    // Reset during a settling dwell
    drive(4'b1011, 8'hDA);
    step(2);
    reset = 1'b1;
    step(1);
    chk_all("midrst", 16'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    step(4);
    chk("midrst.early", 32'(bus.valid), 0);
    step(1);
    chk_all("midrst.cap", 16'h0200, 4'b0100, 4'h0, 4'h0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
